flex_counter_ud: RTL



---
 rtl/flex_counter_ud.sv | 92 +++++++++
 1 files changed

// File: rtl/flex_counter_ud.sv
// Parametrised up/down counter with load, wrap-or-saturate terminal behaviour,
// a one-cycle wrap strobe and a saturating count of wrap events.
module flex_counter_ud #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int NUM_WRAP_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_up,
  input  logic                     saturate,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     rollover_pulse,
  output logic [NUM_WRAP_BITS-1:0] wrap_count
);

  localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO  = '0;
  localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE   = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_WRAP_BITS-1:0] WRAP_ONE  = {{(NUM_WRAP_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_WRAP_BITS-1:0] WRAP_FULL = '1;

  logic [NUM_CNT_BITS-1:0]  count_q, count_d;
  logic                     flag_q, flag_d;
  logic                     pulse_q, pulse_d;
  logic [NUM_WRAP_BITS-1:0] wrap_q, wrap_d;
  logic                     wrap_event;

  always_comb begin
    count_d    = count_q;
    wrap_d     = wrap_q;
    wrap_event = 1'b0;

    if (clear) begin
      count_d = CNT_ZERO;
      wrap_d  = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (count_enable && (rollover_val != CNT_ZERO)) begin
      if (count_up) begin
        // Loaded values above the limit are treated as already at the limit.
        if (count_q < rollover_val) begin
          count_d = count_q + CNT_ONE;
        end else if (saturate) begin
          count_d = rollover_val;
        end else begin
          count_d    = CNT_ONE;
          wrap_event = 1'b1;
        end
      end else begin
        if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
        end else if (!saturate) begin
          count_d    = rollover_val;
          wrap_event = 1'b1;
        end
      end
    end

    if (wrap_event && (wrap_q != WRAP_FULL)) begin
      wrap_d = wrap_q + WRAP_ONE;
    end

    pulse_d = wrap_event;
    // Flag is derived from the next count so it always lines up with count_out.
    flag_d  = (rollover_val != CNT_ZERO) && (count_d == rollover_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      wrap_q  <= '0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out      = count_q;
  assign rollover_flag  = flag_q;
  assign rollover_pulse = pulse_q;
  assign wrap_count     = wrap_q;

endmodule
